// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the write-path arbiter: FSM states, slave
// indices, the slave address map and the owner tags used for ID extension.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AW   = 2'd1,
    W    = 2'd2,
    B    = 2'd3
  } state_t;

  localparam int S0 = 0;
  localparam int S1 = 1;
  localparam int S2 = 2;
  localparam int S3 = 3;
  localparam int S4 = 4;
  localparam int S5 = 5;
  localparam int SD = 6;

  // Each region is aligned to its size, so a hit is (addr & ~mask) == base
  localparam logic [31:0] S0_BASE = 32'h0000_0000;
  localparam logic [31:0] S0_MASK = 32'h0000_3FFF;
  localparam logic [31:0] S1_BASE = 32'h0001_0000;
  localparam logic [31:0] S1_MASK = 32'h0000_FFFF;
  localparam logic [31:0] S2_BASE = 32'h0002_0000;
  localparam logic [31:0] S2_MASK = 32'h0000_FFFF;
  localparam logic [31:0] S3_BASE = 32'h1000_0000;
  localparam logic [31:0] S3_MASK = 32'h0000_03FF;
  localparam logic [31:0] S4_BASE = 32'h1001_0000;
  localparam logic [31:0] S4_MASK = 32'h0000_03FF;
  localparam logic [31:0] S5_BASE = 32'h2000_0000;
  localparam logic [31:0] S5_MASK = 32'h001F_FFFF;

  localparam logic [1:0] TAG_IDLE = 2'b00;
  localparam logic [1:0] TAG_M1   = 2'b10;
  localparam logic [1:0] TAG_M2   = 2'b11;

  function automatic logic in_region(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] mask);
    return (addr & ~mask) == base;
  endfunction

endpackage

// File: rtl/wr_addr_decoder.sv
// Combinational AWADDR to one-hot slave select; unmapped addresses fall
// through to the default slave SD.
module wr_addr_decoder
  import axi_arb_pkg::*;
#(
  parameter int NS = 7
) (
  input  logic [31:0]   addr,
  output logic [NS-1:0] sel
);

  always_comb begin
    sel = '0;
    if      (in_region(addr, S0_BASE, S0_MASK)) sel[S0] = 1'b1;
    else if (in_region(addr, S1_BASE, S1_MASK)) sel[S1] = 1'b1;
    else if (in_region(addr, S2_BASE, S2_MASK)) sel[S2] = 1'b1;
    else if (in_region(addr, S3_BASE, S3_MASK)) sel[S3] = 1'b1;
    else if (in_region(addr, S4_BASE, S4_MASK)) sel[S4] = 1'b1;
    else if (in_region(addr, S5_BASE, S5_MASK)) sel[S5] = 1'b1;
    else                                        sel[SD] = 1'b1;
  end

endmodule

// File: rtl/write_arbiter.sv
// AXI write-path arbiter: round-robin grant between two masters, one complete
// AW/W/B write in flight, with all handshakes gated to the owning pair.
module write_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NM = 2,
  parameter int NS = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NM-1:0]    m_awvalid,
  input  logic [NM*32-1:0] m_awaddr,
  input  logic [NM*4-1:0]  m_awlen,
  output logic [NM-1:0]    m_awready,
  input  logic [NM-1:0]    m_wvalid,
  input  logic [NM-1:0]    m_wlast,
  output logic [NM-1:0]    m_wready,
  output logic [NM-1:0]    m_bvalid,
  input  logic [NM-1:0]    m_bready,
  output logic [NS-1:0]    s_awvalid,
  output logic [NS-1:0]    s_wvalid,
  output logic [NS-1:0]    s_bready,
  input  logic [NS-1:0]    s_awready,
  input  logic [NS-1:0]    s_wready,
  input  logic [NS-1:0]    s_bvalid,
  output logic [NM-1:0]    grant,
  output logic [NS-1:0]    slave_sel,
  output logic [1:0]       master_tag,
  output logic             busy,
  output logic             len_err
);

  state_t        state, state_d;
  logic [NM-1:0] grant_d;
  logic [NS-1:0] sel_d;
  logic          rr_ptr, rr_d;
  logic [3:0]    awlen_q, awlen_d;
  logic [3:0]    beat, beat_d;
  logic          len_err_d;

  logic          win;
  logic [31:0]   win_addr;
  logic [3:0]    win_len;
  logic [NS-1:0] win_sel;
  logic          aw_hs, w_hs, b_hs, wlast_g;

  // With both masters requesting the pointer decides; otherwise the lone requester wins
  assign win      = (&m_awvalid) ? rr_ptr : m_awvalid[1];
  assign win_addr = win ? m_awaddr[32 +: 32] : m_awaddr[0 +: 32];
  assign win_len  = win ? m_awlen[4 +: 4]    : m_awlen[0 +: 4];

  wr_addr_decoder #(.NS(NS)) u_decoder (
    .addr (win_addr),
    .sel  (win_sel)
  );

  assign busy       = (state != IDLE);
  assign master_tag = grant[0] ? TAG_M1 : (grant[1] ? TAG_M2 : TAG_IDLE);

  assign s_awvalid = (state == AW && |(m_awvalid & grant))  ? slave_sel : '0;
  assign m_awready = (state == AW && |(s_awready & slave_sel)) ? grant  : '0;
  assign s_wvalid  = (state == W  && |(m_wvalid  & grant))  ? slave_sel : '0;
  assign m_wready  = (state == W  && |(s_wready  & slave_sel)) ? grant  : '0;
  assign m_bvalid  = (state == B  && |(s_bvalid  & slave_sel)) ? grant  : '0;
  assign s_bready  = (state == B  && |(m_bready  & grant))  ? slave_sel : '0;

  assign aw_hs   = |(m_awvalid & m_awready);
  assign w_hs    = |(m_wvalid & m_wready);
  assign b_hs    = |(m_bvalid & m_bready);
  assign wlast_g = |(m_wlast & grant);

  always_comb begin
    state_d   = state;
    grant_d   = grant;
    sel_d     = slave_sel;
    rr_d      = rr_ptr;
    awlen_d   = awlen_q;
    beat_d    = beat;
    len_err_d = 1'b0;
    case (state)
      IDLE: begin
        if (|m_awvalid) begin
          grant_d      = '0;
          grant_d[win] = 1'b1;
          sel_d        = win_sel;
          awlen_d      = win_len;
          state_d      = AW;
        end
      end
      AW: begin
        if (aw_hs) begin
          beat_d  = 4'd0;
          state_d = W;
        end
      end
      W: begin
        // A mismatch is flagged but only WLAST ever closes the burst
        if (w_hs) begin
          beat_d    = beat + 4'd1;
          len_err_d = (wlast_g != (beat == awlen_q));
          if (wlast_g) state_d = B;
        end
      end
      B: begin
        if (b_hs) begin
          grant_d = '0;
          sel_d   = '0;
          rr_d    = ~grant[1];
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      grant     <= '0;
      slave_sel <= '0;
      rr_ptr    <= 1'b0;
      awlen_q   <= 4'd0;
      beat      <= 4'd0;
      len_err   <= 1'b0;
    end else begin
      state     <= state_d;
      grant     <= grant_d;
      slave_sel <= sel_d;
      rr_ptr    <= rr_d;
      awlen_q   <= awlen_d;
      beat      <= beat_d;
      len_err   <= len_err_d;
    end
  end

endmodule

// File: tb/tb_write_arbiter.sv
// Self-checking bench for write_arbiter: scenario tasks with randomized slave
// stalls, checked against an address-range and beat-count reference model.
module tb_write_arbiter;

  localparam int NM = 2;
  localparam int NS = 7;

  logic             clk = 1'b0;
  logic             rst;
  logic [NM-1:0]    m_awvalid, m_awready, m_wvalid, m_wlast, m_wready, m_bvalid, m_bready;
  logic [NM*32-1:0] m_awaddr;
  logic [NM*4-1:0]  m_awlen;
  logic [NS-1:0]    s_awvalid, s_wvalid, s_bready, s_awready, s_wready, s_bvalid;
  logic [NM-1:0]    grant;
  logic [NS-1:0]    slave_sel;
  logic [1:0]       master_tag;
  logic             busy, len_err;

  int checks = 0;
  int passes = 0;
  int model_rr = 0;

  always #5 clk = ~clk;

  write_arbiter #(.NM(NM), .NS(NS)) dut (
    .clk(clk), .rst(rst),
    .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .s_awvalid(s_awvalid), .s_wvalid(s_wvalid), .s_bready(s_bready),
    .s_awready(s_awready), .s_wready(s_wready), .s_bvalid(s_bvalid),
    .grant(grant), .slave_sel(slave_sel), .master_tag(master_tag),
    .busy(busy), .len_err(len_err)
  );

  // Reference address map, written as inclusive address ranges
  function automatic int ref_slave(input logic [31:0] a);
    if (a <= 32'h0000_3FFF) return 0;
    if (a >= 32'h0001_0000 && a <= 32'h0001_FFFF) return 1;
    if (a >= 32'h0002_0000 && a <= 32'h0002_FFFF) return 2;
    if (a >= 32'h1000_0000 && a <= 32'h1000_03FF) return 3;
    if (a >= 32'h1001_0000 && a <= 32'h1001_03FF) return 4;
    if (a >= 32'h2000_0000 && a <= 32'h201F_FFFF) return 5;
    return 6;
  endfunction

  function automatic logic [6:0] ref_onehot(input logic [31:0] a);
    return 7'(1) << ref_slave(a);
  endfunction

  function automatic int ref_winner(input logic [1:0] req, input int rr);
    if (req == 2'b01) return 0;
    if (req == 2'b10) return 1;
    return rr;
  endfunction

  // Beat k (0-based) is faulty when "is last" disagrees with "k equals awlen"
  function automatic int ref_len_errs(input int len, input int nbeats);
    int n = 0;
    for (int k = 0; k < nbeats; k++)
      if ((k == nbeats - 1) != (k == len)) n++;
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_awvalid = '0; m_awaddr = '0; m_awlen = '0;
    m_wvalid = '0; m_wlast = '0; m_bready = '0;
    s_awready = '0; s_wready = '0; s_bvalid = '0;
  endtask

  // Drives one full write for master m (WLAST on the final beat) and records observations
  task automatic run_write(input int m, input logic [31:0] addr, input logic [3:0] len,
                           input int nbeats, input bit stall, input bit pester,
                           output logic [1:0] g_seen, output logic [6:0] sel_seen,
                           output logic [1:0] tag_seen, output bit lat_ok, output int lerr,
                           output int hs_w, output int viol, output bit busy_after,
                           output bit timeout);
    int o = 1 - m;
    int sl = ref_slave(addr);
    logic [6:0] sel_oh = ref_onehot(addr);
    int cyc;
    lerr = 0; hs_w = 0; viol = 0; timeout = 0; lat_ok = 0; busy_after = 1;
    g_seen = 'x; sel_seen = 'x; tag_seen = 'x;
    s_wready = '1; s_bvalid = '1;
    m_awaddr[m*32 +: 32] = addr;
    m_awlen[m*4 +: 4] = len;
    m_awvalid[m] = 1'b1;
    if (pester) begin m_wvalid[o] = 1'b1; m_bready[o] = 1'b1; end
    #1;
    lat_ok = (s_awvalid == '0);
    tick();
    g_seen = grant; sel_seen = slave_sel; tag_seen = master_tag;
    lat_ok = lat_ok && (s_awvalid == sel_oh);
    cyc = 0;
    forever begin
      s_awready = stall ? 7'($urandom) : 7'h7F;
      #1;
      if (m_awready[m] !== s_awready[sl] || m_awready[o] !== 1'b0) viol++;
      if (s_wvalid !== '0 || m_wready !== '0 || m_bvalid !== '0) viol++;
      if (m_awready[m] === 1'b1) break;
      tick();
      if (++cyc > 100) begin timeout = 1; return; end
    end
    tick();
    if (len_err) lerr++;
    m_awvalid[m] = 1'b0;
    cyc = 0;
    while (hs_w < nbeats) begin
      m_wvalid[m] = 1'b1;
      m_wlast[m] = (hs_w == nbeats - 1);
      s_wready = stall ? 7'($urandom) : 7'h7F;
      #1;
      if (m_wready[m] !== s_wready[sl] || s_wvalid !== sel_oh || m_wready[o] !== 1'b0) viol++;
      if (m_bvalid !== '0 || m_awready !== '0 || s_awvalid !== '0) viol++;
      if (m_wready[m] === 1'b1) hs_w++;
      tick();
      if (len_err) lerr++;
      if (++cyc > 200) begin timeout = 1; return; end
    end
    m_wvalid[m] = 1'b0; m_wlast[m] = 1'b0;
    m_bready[m] = 1'b1;
    cyc = 0;
    forever begin
      s_bvalid = stall ? 7'($urandom) : 7'h7F;
      #1;
      if (m_bvalid[m] !== s_bvalid[sl] || s_bready !== sel_oh || m_bvalid[o] !== 1'b0) viol++;
      if (m_wready !== '0 || s_wvalid !== '0) viol++;
      if (m_bvalid[m] === 1'b1) break;
      tick();
      if (len_err) lerr++;
      if (++cyc > 100) begin timeout = 1; return; end
    end
    tick();
    if (len_err) lerr++;
    m_bready[m] = 1'b0;
    busy_after = busy;
    s_awready = '1; s_wready = '1; s_bvalid = '1;
    if (pester) begin m_wvalid[o] = 1'b0; m_bready[o] = 1'b0; end
    model_rr = o;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    m_awvalid = '1; m_wvalid = '1; m_bready = '1;
    s_awready = '1; s_wready = '1; s_bvalid = '1;
    #2 rst = 1'b0;
    #1;
    checks++; if ({grant, slave_sel, master_tag, busy, len_err} !== '0)
      $display("[TB] FAIL reset_state got %b want 0", {grant, slave_sel, master_tag, busy, len_err}); else passes++;
    checks++; if ({m_awready, m_wready, m_bvalid, s_awvalid, s_wvalid, s_bready} !== '0)
      $display("[TB] FAIL reset_handshakes got %b want 0", {m_awready, m_wready, m_bvalid, s_awvalid, s_wvalid, s_bready}); else passes++;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({grant, busy, s_awvalid} !== '0)
      $display("[TB] FAIL reset_held got %b want 0", {grant, busy, s_awvalid}); else passes++;
    clear_inputs();
    @(negedge clk) rst = 1'b1;
    model_rr = 0;
    tick();
    checks++; if ({grant, busy} !== '0)
      $display("[TB] FAIL idle_after_reset got %b want 0", {grant, busy}); else passes++;
  endtask

  task automatic test_arbitration();
    logic [31:0] addr_of [2] = '{32'h0000_0100, 32'h1000_0010};
    logic [1:0] g; logic [6:0] sel; logic [1:0] tag;
    bit lat, ba, tmo; int lerr, hsw, viol, w;
    m_awaddr[32 +: 32] = addr_of[1];
    m_awvalid[1] = 1'b1;
    w = ref_winner(2'b11, model_rr);
    run_write(w, addr_of[w], 4'd0, 1, 1'b0, 1'b0, g, sel, tag, lat, lerr, hsw, viol, ba, tmo);
    checks++; if (g !== 2'(1 << w)) $display("[TB] FAIL arb_first_grant got %b want %b", g, 2'(1 << w)); else passes++;
    checks++; if (sel !== ref_onehot(addr_of[w])) $display("[TB] FAIL arb_first_sel got %b want %b", sel, ref_onehot(addr_of[w])); else passes++;
    checks++; if (viol !== 0 || tmo !== 1'b0) $display("[TB] FAIL arb_first_gating got viol=%0d tmo=%0d want 0/0", viol, tmo); else passes++;
    m_awvalid = '1;
    w = ref_winner(2'b11, model_rr);
    run_write(w, addr_of[w], 4'd0, 1, 1'b0, 1'b0, g, sel, tag, lat, lerr, hsw, viol, ba, tmo);
    m_awvalid = '0;
    checks++; if (g !== 2'(1 << w)) $display("[TB] FAIL arb_second_grant got %b want %b", g, 2'(1 << w)); else passes++;
    checks++; if (tag !== (w == 1 ? 2'b11 : 2'b10)) $display("[TB] FAIL arb_second_tag got %b want %b", tag, (w == 1 ? 2'b11 : 2'b10)); else passes++;
    checks++; if (viol !== 0 || tmo !== 1'b0) $display("[TB] FAIL arb_second_gating got viol=%0d tmo=%0d want 0/0", viol, tmo); else passes++;
  endtask

  task automatic test_single_m1();
    logic [1:0] g; logic [6:0] sel; logic [1:0] tag;
    bit lat, ba, tmo; int lerr, hsw, viol;
    run_write(0, 32'h0002_0010, 4'd0, 1, 1'b0, 1'b0, g, sel, tag, lat, lerr, hsw, viol, ba, tmo);
    checks++; if (g !== 2'b01) $display("[TB] FAIL m1_grant got %b want %b", g, 2'b01); else passes++;
    checks++; if (sel !== ref_onehot(32'h0002_0010)) $display("[TB] FAIL m1_sel got %b want %b", sel, ref_onehot(32'h0002_0010)); else passes++;
    checks++; if (tag !== 2'b10) $display("[TB] FAIL m1_tag got %b want %b", tag, 2'b10); else passes++;
    checks++; if (lat !== 1'b1) $display("[TB] FAIL m1_aw_latency got %0d want 1", lat); else passes++;
    checks++; if (ba !== 1'b0) $display("[TB] FAIL m1_busy_after_b got %0d want 0", ba); else passes++;
    checks++; if (lerr !== ref_len_errs(0, 1) || viol !== 0) $display("[TB] FAIL m1_clean got lerr=%0d viol=%0d want %0d/0", lerr, viol, ref_len_errs(0, 1)); else passes++;
  endtask

  task automatic test_sd_burst();
    logic [1:0] g; logic [6:0] sel; logic [1:0] tag;
    bit lat, ba, tmo; int lerr, hsw, viol;
    run_write(1, 32'h3000_0000, 4'd3, 4, 1'b1, 1'b0, g, sel, tag, lat, lerr, hsw, viol, ba, tmo);
    checks++; if (sel !== ref_onehot(32'h3000_0000)) $display("[TB] FAIL sd_sel got %b want %b", sel, ref_onehot(32'h3000_0000)); else passes++;
    checks++; if (lerr !== ref_len_errs(3, 4)) $display("[TB] FAIL sd_len_err got %0d want %0d", lerr, ref_len_errs(3, 4)); else passes++;
    checks++; if (viol !== 0) $display("[TB] FAIL sd_wready_follow got %0d want 0", viol); else passes++;
    checks++; if (hsw !== 4 || tmo !== 1'b0) $display("[TB] FAIL sd_beats got %0d tmo=%0d want 4/0", hsw, tmo); else passes++;
  endtask

  task automatic test_len_err();
    logic [1:0] g; logic [6:0] sel; logic [1:0] tag;
    bit lat, ba, tmo; int lerr, hsw, viol;
    run_write(0, 32'h0001_0040, 4'd3, 2, 1'b0, 1'b0, g, sel, tag, lat, lerr, hsw, viol, ba, tmo);
    checks++; if (lerr !== ref_len_errs(3, 2)) $display("[TB] FAIL early_wlast_err got %0d want %0d", lerr, ref_len_errs(3, 2)); else passes++;
    checks++; if (hsw !== 2 || tmo !== 1'b0 || ba !== 1'b0) $display("[TB] FAIL early_wlast_end got beats=%0d tmo=%0d busy=%0d want 2/0/0", hsw, tmo, ba); else passes++;
    run_write(0, 32'h0000_0200, 4'd1, 3, 1'b0, 1'b0, g, sel, tag, lat, lerr, hsw, viol, ba, tmo);
    checks++; if (lerr !== ref_len_errs(1, 3)) $display("[TB] FAIL missing_wlast_err got %0d want %0d", lerr, ref_len_errs(1, 3)); else passes++;
    checks++; if (hsw !== 3 || tmo !== 1'b0) $display("[TB] FAIL missing_wlast_stays got beats=%0d tmo=%0d want 3/0", hsw, tmo); else passes++;
  endtask

  task automatic test_isolation();
    logic [1:0] g; logic [6:0] sel; logic [1:0] tag;
    bit lat, ba, tmo; int lerr, hsw, viol;
    run_write(0, 32'h2010_0000, 4'd2, 3, 1'b1, 1'b1, g, sel, tag, lat, lerr, hsw, viol, ba, tmo);
    checks++; if (sel !== ref_onehot(32'h2010_0000)) $display("[TB] FAIL iso_sel got %b want %b", sel, ref_onehot(32'h2010_0000)); else passes++;
    checks++; if (viol !== 0 || tmo !== 1'b0) $display("[TB] FAIL iso_gating got viol=%0d tmo=%0d want 0/0", viol, tmo); else passes++;
    checks++; if (lerr !== ref_len_errs(2, 3)) $display("[TB] FAIL iso_len_err got %0d want %0d", lerr, ref_len_errs(2, 3)); else passes++;
  endtask

  task automatic test_random();
    logic [31:0] lo [6] = '{32'h0000_0000, 32'h0001_0000, 32'h0002_0000, 32'h1000_0000, 32'h1001_0000, 32'h2000_0000};
    logic [31:0] hi [6] = '{32'h0000_3FFF, 32'h0001_FFFF, 32'h0002_FFFF, 32'h1000_03FF, 32'h1001_03FF, 32'h201F_FFFF};
    logic [1:0] g; logic [6:0] sel; logic [1:0] tag;
    bit lat, ba, tmo; int lerr, hsw, viol;
    for (int it = 0; it < 8; it++) begin
      int m = $urandom_range(0, 1);
      int r = $urandom_range(0, 5);
      int kind = $urandom_range(0, 3);
      int len = $urandom_range(0, 3);
      int nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : len + 1;
      logic [31:0] a;
      if (kind == 0)      a = $urandom;
      else if (kind == 1) a = hi[r] + 32'd1;
      else                a = lo[r] + ($urandom % (hi[r] - lo[r] + 32'd1));
      run_write(m, a, 4'(len), nb, 1'($urandom_range(0, 1)), 1'b0, g, sel, tag, lat, lerr, hsw, viol, ba, tmo);
      checks++; if (sel !== ref_onehot(a)) $display("[TB] FAIL rand_sel addr=%h got %b want %b", a, sel, ref_onehot(a)); else passes++;
      checks++; if (g !== 2'(1 << m) || tag !== (m == 1 ? 2'b11 : 2'b10)) $display("[TB] FAIL rand_owner got g=%b tag=%b want m=%0d", g, tag, m); else passes++;
      checks++; if (lerr !== ref_len_errs(len, nb)) $display("[TB] FAIL rand_len_err len=%0d beats=%0d got %0d want %0d", len, nb, lerr, ref_len_errs(len, nb)); else passes++;
      checks++; if (viol !== 0 || tmo !== 1'b0 || hsw !== nb || ba !== 1'b0) $display("[TB] FAIL rand_flow got viol=%0d tmo=%0d beats=%0d busy=%0d want 0/0/%0d/0", viol, tmo, hsw, ba, nb); else passes++;
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [1:0] g; logic [6:0] sel; logic [1:0] tag;
    bit lat, ba, tmo; int lerr, hsw, viol, w;
    run_write(0, 32'h0000_1000, 4'd0, 1, 1'b0, 1'b0, g, sel, tag, lat, lerr, hsw, viol, ba, tmo);
    checks++; if (tmo !== 1'b0) $display("[TB] FAIL pre_reset_write got tmo=%0d want 0", tmo); else passes++;
    m_awaddr[0 +: 32] = 32'h2000_0040; m_awlen[0 +: 4] = 4'd3; m_awvalid[0] = 1'b1;
    s_awready = '1; s_wready = '1; s_bvalid = '1;
    tick();
    tick();
    m_awvalid[0] = 1'b0; m_wvalid[0] = 1'b1; m_bready = '1;
    #1;
    checks++; if (busy !== 1'b1 || m_wready[0] !== 1'b1) $display("[TB] FAIL mid_burst_in_w got busy=%0d wready=%0d want 1/1", busy, m_wready[0]); else passes++;
    tick();
    #2 rst = 1'b0;
    #1;
    checks++; if ({grant, slave_sel, master_tag, busy, len_err} !== '0)
      $display("[TB] FAIL mid_reset_state got %b want 0", {grant, slave_sel, master_tag, busy, len_err}); else passes++;
    checks++; if ({m_awready, m_wready, m_bvalid, s_awvalid, s_wvalid, s_bready} !== '0)
      $display("[TB] FAIL mid_reset_handshakes got %b want 0", {m_awready, m_wready, m_bvalid, s_awvalid, s_wvalid, s_bready}); else passes++;
    clear_inputs();
    @(negedge clk) rst = 1'b1;
    model_rr = 0;
    tick();
    m_awaddr = {32'h1000_0000, 32'h0001_0000};
    m_awvalid = '1;
    w = ref_winner(2'b11, model_rr);
    tick();
    checks++; if (grant !== 2'(1 << w)) $display("[TB] FAIL post_reset_rr got %b want %b", grant, 2'(1 << w)); else passes++;
    checks++; if (slave_sel !== ref_onehot(m_awaddr[w*32 +: 32])) $display("[TB] FAIL post_reset_sel got %b want %b", slave_sel, ref_onehot(m_awaddr[w*32 +: 32])); else passes++;
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_single_m1();
    test_sd_burst();
    test_len_err();
    test_isolation();
    test_random();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
